wave_meas: RTL and testbench

//  Memory-mapped waveform analyser for the picosoc peripheral bus; the receiving end of the wave generator.
//  It samples a 32-bit wave bus and digitises it, either as bit 0 or as a threshold compare.
//  It measures period, high time, rising-edge count and running min/max, and the CPU reads the results.

---
 rtl/wave_meas.sv | 134 +++++++++++++
 tb/tb_wave_meas.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/wave_meas.sv
// Memory-mapped waveform analyser: digitises a 32-bit wave bus and measures
// period, high time, rising-edge count and running min/max for CPU readout.
module wave_meas #(
   parameter int unsigned CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        sel,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   input  logic [31:0] wave_in
);

   typedef enum logic [1:0] {
      StIdle     = 2'd0,
      StWaitRise = 2'd1,
      StMeasure  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CntMax = '1;

   state_t           r_state;
   logic             r_en;
   logic             r_mode;
   logic [31:0]      r_thresh;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_period;
   logic [CNT_W-1:0] r_high;
   logic [31:0]      r_min;
   logic [31:0]      r_max;
   logic [31:0]      r_edges;
   logic             r_valid;
   logic             r_ovf;
   logic             r_d_q;

   logic       w_we;
   logic [2:0] w_reg;
   logic       w_clr;
   logic       w_d;
   logic       w_rise;
   logic       w_fall;

   assign w_we   = sel & (|wstrb);
   assign w_reg  = addr[4:2];
   assign w_clr  = w_we && (w_reg == 3'd0) && wdata[2];
   assign w_d    = r_mode ? (wave_in >= r_thresh) : wave_in[0];
   assign w_rise = w_d & ~r_d_q;
   assign w_fall = ~w_d & r_d_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= StIdle;
         r_en     <= 1'b0;
         r_mode   <= 1'b0;
         r_thresh <= '0;
         r_cnt    <= '0;
         r_period <= '0;
         r_high   <= '0;
         r_min    <= 32'hFFFF_FFFF;
         r_max    <= '0;
         r_edges  <= '0;
         r_valid  <= 1'b0;
         r_ovf    <= 1'b0;
         r_d_q    <= 1'b0;
      end else begin
         r_d_q <= w_d;
         if (w_we && (w_reg == 3'd0)) begin
            r_en   <= wdata[0];
            r_mode <= wdata[1];
         end
         if (w_we && (w_reg == 3'd1)) begin
            r_thresh <= wdata;
         end
         // CLR overrides any edge, saturation or min/max update in the same cycle
         if (w_clr) begin
            r_cnt    <= '0;
            r_period <= '0;
            r_high   <= '0;
            r_edges  <= '0;
            r_valid  <= 1'b0;
            r_ovf    <= 1'b0;
            r_min    <= 32'hFFFF_FFFF;
            r_max    <= '0;
            r_state  <= wdata[0] ? StWaitRise : StIdle;
         end else if (!r_en) begin
            r_state <= StIdle;
         end else begin
            if (wave_in < r_min) r_min <= wave_in;
            if (wave_in > r_max) r_max <= wave_in;
            case (r_state)
               StIdle: r_state <= StWaitRise;
               StWaitRise: begin
                  if (w_rise) begin
                     r_state <= StMeasure;
                     r_cnt   <= CNT_W'(1);
                     r_edges <= r_edges + 32'd1;
                  end
               end
               StMeasure: begin
                  if (w_rise) begin
                     r_period <= r_cnt;
                     r_valid  <= 1'b1;
                     r_cnt    <= CNT_W'(1);
                     r_edges  <= r_edges + 32'd1;
                  end else begin
                     if (w_fall) r_high <= r_cnt;
                     if (r_cnt == CntMax) r_ovf <= 1'b1;
                     else r_cnt <= r_cnt + CNT_W'(1);
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   always_comb begin
      rdata = '0;
      case (w_reg)
         3'd0: rdata = {30'd0, r_mode, r_en};
         3'd1: rdata = r_thresh;
         3'd2: rdata = 32'(r_period);
         3'd3: rdata = 32'(r_high);
         3'd4: rdata = r_min;
         3'd5: rdata = r_max;
         3'd6: rdata = {28'd0, r_state, r_ovf, r_valid};
         3'd7: rdata = r_edges;
         default: rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_wave_meas.sv
// Directed bench for wave_meas: a 32-bit counter instance for the main cases
// and an 8-bit counter instance for saturation.
module tb_wave_meas;

   logic        clk = 1'b0;
   logic        rst;
   logic        sel, sel8;
   logic [3:0]  wstrb;
   logic [31:0] addr, wdata, wave;
   logic [31:0] rdata, rdata8;

   int n_checks = 0;
   int n_errors = 0;

   localparam logic [2:0] RCtrl = 3'd0, RThresh = 3'd1, RPeriod = 3'd2, RHigh = 3'd3;
   localparam logic [2:0] RMin = 3'd4, RMax = 3'd5, RStatus = 3'd6, REdges = 3'd7;

   always #10 clk = ~clk;

   wave_meas #(.CNT_W(32)) dut (
      .clk(clk), .rst(rst), .sel(sel), .wstrb(wstrb), .addr(addr),
      .wdata(wdata), .rdata(rdata), .wave_in(wave)
   );

   wave_meas #(.CNT_W(8)) dut8 (
      .clk(clk), .rst(rst), .sel(sel8), .wstrb(wstrb), .addr(addr),
      .wdata(wdata), .rdata(rdata8), .wave_in(wave)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic rd_chk(input int which, input logic [2:0] r, input logic [31:0] exp,
                         input string tag);
      addr = {27'd0, r, 2'b00};
      #1;
      check(tag, (which == 1) ? rdata8 : rdata, exp);
   endtask

   task automatic wr(input int which, input logic [2:0] r, input logic [31:0] data);
      addr  = {27'd0, r, 2'b00};
      wdata = data;
      wstrb = 4'hF;
      if (which == 1) sel8 = 1'b1;
      else sel = 1'b1;
      tick();
      sel   = 1'b0;
      sel8  = 1'b0;
      wstrb = 4'h0;
   endtask

   initial begin
      rst = 1'b1; sel = 1'b0; sel8 = 1'b0; wstrb = 4'h0;
      addr = '0; wdata = '0; wave = '0;
      #3;
      rd_chk(0, RCtrl,   32'h0,         "rst_ctrl");
      rd_chk(0, RThresh, 32'h0,         "rst_thresh");
      rd_chk(0, RPeriod, 32'h0,         "rst_period");
      rd_chk(0, RHigh,   32'h0,         "rst_high");
      rd_chk(0, RMin,    32'hFFFF_FFFF, "rst_min");
      rd_chk(0, RMax,    32'h0,         "rst_max");
      rd_chk(0, RStatus, 32'h0,         "rst_status");
      rd_chk(0, REdges,  32'h0,         "rst_edges");
      tick(); tick();
      rst = 1'b0;

      // 1: square wave on bit 0, 5 high / 5 low
      wr(0, RCtrl, 32'h1);
      rd_chk(0, RCtrl, 32'h1, "t1_ctrl");
      tick(); tick();
      rd_chk(0, RStatus, 32'h4, "t1_wait_rise");
      for (int i = 0; i < 40; i++) begin
         wave = ((i / 5) % 2 == 0) ? 32'd1 : 32'd0;
         if (i == 10) rd_chk(0, RStatus, 32'h8, "t1_not_valid");
         if (i == 11) rd_chk(0, RStatus, 32'h9, "t1_valid");
         tick();
      end
      rd_chk(0, RPeriod, 32'd10, "t1_period");
      rd_chk(0, RHigh,   32'd5,  "t1_high");
      rd_chk(0, REdges,  32'd4,  "t1_edges");
      rd_chk(0, RStatus, 32'h9,  "t1_status");

      // 2: PWM 3 high / 7 low after CLR
      wave = 32'd0;
      wr(0, RCtrl, 32'h5);
      rd_chk(0, RCtrl,   32'h1, "t2_ctrl_clr_reads0");
      rd_chk(0, RPeriod, 32'h0, "t2_clr_period");
      rd_chk(0, RStatus, 32'h4, "t2_clr_status");
      for (int i = 0; i < 40; i++) begin
         wave = ((i % 10) < 3) ? 32'd1 : 32'd0;
         tick();
      end
      rd_chk(0, RPeriod, 32'd10, "t2_period");
      rd_chk(0, RHigh,   32'd3,  "t2_high");
      rd_chk(0, RMin,    32'd0,  "t2_min");
      rd_chk(0, RMax,    32'd1,  "t2_max");
      rd_chk(0, REdges,  32'd4,  "t2_edges");
      wr(0, RPeriod, 32'h1234);
      rd_chk(0, RPeriod, 32'd10, "t2_ro_write_ignored");

      // 3: threshold mode on a 0..255 sawtooth
      wr(0, RThresh, 32'd100);
      rd_chk(0, RThresh, 32'd100, "t3_thresh");
      wr(0, RCtrl, 32'h7);
      for (int i = 0; i < 613; i++) begin
         wave = 32'(i % 256);
         tick();
      end
      rd_chk(0, RPeriod, 32'd256, "t3_period");
      rd_chk(0, RHigh,   32'd156, "t3_high");
      rd_chk(0, RMin,    32'd0,   "t3_min");
      rd_chk(0, RMax,    32'd255, "t3_max");
      rd_chk(0, REdges,  32'd3,   "t3_edges");
      rd_chk(0, RStatus, 32'h9,   "t3_status");

      // 5: CLR coincident with a rise
      wave = 32'd0;
      wr(0, RCtrl, 32'h1);
      tick(); tick();
      wave = 32'd1;
      wr(0, RCtrl, 32'h5);
      rd_chk(0, RPeriod, 32'h0, "t5_period");
      rd_chk(0, RHigh,   32'h0, "t5_high");
      rd_chk(0, REdges,  32'h0, "t5_edges");
      rd_chk(0, RStatus, 32'h4, "t5_status");
      tick();
      rd_chk(0, RStatus, 32'h4, "t5_still_waiting");
      rd_chk(0, REdges,  32'h0, "t5_edges_after");
      rd_chk(0, RMin,    32'd1, "t5_min");
      rd_chk(0, RMax,    32'd1, "t5_max");

      // 4: 8-bit counter saturation on the second instance
      wave = 32'd0;
      wr(1, RCtrl, 32'h5);
      wave = 32'd1;
      tick();
      for (int i = 0; i < 299; i++) begin
         if (i == 100) rd_chk(1, RStatus, 32'h8, "t4_no_ovf_yet");
         tick();
      end
      rd_chk(1, RPeriod, 32'd0,  "t4_period_held");
      rd_chk(1, RStatus, 32'hA,  "t4_ovf");
      wave = 32'd0;
      tick();
      wave = 32'd1;
      tick();
      rd_chk(1, RPeriod, 32'd255, "t4_period_sat");
      rd_chk(1, RHigh,   32'd255, "t4_high_sat");
      rd_chk(1, RStatus, 32'hB,   "t4_status");
      rd_chk(1, REdges,  32'd2,   "t4_edges");

      // 6: asynchronous reset mid-measurement
      wave = 32'd0;
      wr(0, RCtrl, 32'h5);
      wave = 32'd1;
      tick();
      wave = 32'd0;
      tick(); tick();
      rd_chk(0, RStatus, 32'h8, "t6_measuring");
      #3;
      rst = 1'b1;
      rd_chk(0, RStatus, 32'h0,         "t6_rst_status");
      rd_chk(0, RMin,    32'hFFFF_FFFF, "t6_rst_min");
      rd_chk(0, RMax,    32'h0,         "t6_rst_max");
      #1;
      rst = 1'b0;
      wave = 32'd1; tick();
      wave = 32'd0; tick();
      wave = 32'd1; tick();
      rd_chk(0, RStatus, 32'h0, "t6_idle_after");
      rd_chk(0, REdges,  32'h0, "t6_edges_after");
      rd_chk(0, RCtrl,   32'h0, "t6_ctrl_after");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
